// File: rtl/genius_seq_ctrl.sv
// genius_seq_ctrl: Simon-style sequencer that grows, plays back and checks a random color sequence
module genius_seq_ctrl #(
  parameter int          MAX_LEN       = 16,
  parameter int          ON_TICKS      = 25_000_000,
  parameter int          GAP_TICKS     = 12_500_000,
  parameter int          TIMEOUT_TICKS = 250_000_000,
  parameter logic [7:0]  SEED          = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [3:0]                   btn,
  output logic [1:0]                   cor,
  output logic                         enable,
  output logic [$clog2(MAX_LEN+1)-1:0] level,
  output logic                         busy,
  output logic                         win,
  output logic                         lose
);
  localparam int LW    = $clog2(MAX_LEN + 1);
  localparam int MAXOG = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int MAXT  = (MAXOG > TIMEOUT_TICKS) ? MAXOG : TIMEOUT_TICKS;
  localparam int TW    = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [TW-1:0] T_ON  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] T_GAP = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] T_TO  = TW'(TIMEOUT_TICKS - 1);
  typedef enum logic [3:0] {IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, ECHO, PAUSE, WIN, LOSE} state_t;
  state_t                   state_q, state_d;
  logic [LW-1:0]            len_q, len_d, idx_q, idx_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [7:0]               lfsr_q, lfsr_d;
  logic [MAX_LEN-1:0][1:0]  seq_q, seq_d;
  logic [3:0]               btn_q, btn_d;
  logic [1:0]               pcol_q, pcol_d;
  logic [1:0]               seq_cur, btn_col;
  logic                     press, timer_zero, last;
  assign press      = (btn != 4'd0) && (btn_q == 4'd0);
  assign timer_zero = timer_q == '0;
  assign last       = idx_q == len_q - LW'(1);
  assign btn_col    = btn[3] ? 2'd3 : btn[2] ? 2'd2 : btn[1] ? 2'd1 : 2'd0;
  // color stored at the current playback/echo position
  always_comb begin
    seq_cur = 2'd0;
    for (int i = 0; i < MAX_LEN; i++) if (idx_q == LW'(i)) seq_cur = seq_q[i];
  end
  // game state machine next-state logic; the LFSR free-runs so round colors depend on player timing
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    seq_d   = seq_q;
    pcol_d  = pcol_q;
    btn_d   = btn;
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    case (state_q)
      IDLE, WIN, LOSE: if (start) begin
        len_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        for (int i = 0; i < MAX_LEN; i++) if (len_q == LW'(i)) seq_d[i] = lfsr_q[1:0];
        len_d   = len_q + LW'(1);
        idx_d   = '0;
        timer_d = T_ON;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        timer_d = timer_zero ? T_GAP : timer_q - TW'(1);
        state_d = timer_zero ? SHOW_OFF : SHOW_ON;
      end
      SHOW_OFF: if (!timer_zero) timer_d = timer_q - TW'(1);
      else if (last) begin
        idx_d   = '0;
        timer_d = T_TO;
        state_d = WAIT_IN;
      end else begin
        idx_d   = idx_q + LW'(1);
        timer_d = T_ON;
        state_d = SHOW_ON;
      end
      WAIT_IN: begin
        timer_d = timer_q - TW'(1);
        if (press) begin
          pcol_d  = btn_col;
          state_d = ($onehot(btn) && btn_col == seq_cur) ? ECHO : LOSE;
        end else if (timer_zero) state_d = LOSE;
      end
      ECHO: if (btn == 4'd0) begin
        if (!last) begin
          idx_d   = idx_q + LW'(1);
          timer_d = T_TO;
          state_d = WAIT_IN;
        end else if (len_q == LW'(MAX_LEN)) state_d = WIN;
        else begin
          timer_d = T_GAP;
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        timer_d = timer_q - TW'(1);
        state_d = timer_zero ? ADD : PAUSE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      lfsr_q  <= SEED;
      seq_q   <= '0;
      btn_q   <= '0;
      pcol_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      seq_q   <= seq_d;
      btn_q   <= btn_d;
      pcol_q  <= pcol_d;
    end
  end
  assign level  = len_q;
  assign enable = (state_q == SHOW_ON) || (state_q == ECHO);
  assign cor    = (state_q == SHOW_ON) ? seq_cur : (state_q == ECHO) ? pcol_q : 2'd0;
  assign busy   = !(state_q == IDLE || state_q == WIN || state_q == LOSE);
  assign win    = state_q == WIN;
  assign lose   = state_q == LOSE;
endmodule
